// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and constants for the miner result path
package miner_pkg;

  // One miner nonce
  typedef logic [31:0] nonce_t;

  // Width of the saturating hit counter
  localparam int FOUND_CNT_W = 16;

  // Default result FIFO depth
  localparam int COLLECTOR_DEPTH = 8;

endpackage

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - result FIFO with registered head, sync clear and async reset
// The caller guarantees push only with room and pop only with a valid head.
module nonce_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 40
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_head_valid;
  logic [W-1:0]     r_head_data;

  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [LVL_W-1:0] w_level_nxt;
  logic [W-1:0]     w_head_nxt;
  logic             w_write;

  // Next pointers, occupancy and head entry; a pushed entry landing at the
  // next read slot is forwarded so the head register never shows stale data
  always_comb begin
    w_write      = push && !clear;
    w_rd_ptr_nxt = pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_wr_ptr_nxt = push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
    w_level_nxt  = r_level + LVL_W'(push) - LVL_W'(pop);
    if (clear) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_level_nxt  = '0;
    end
    w_head_nxt = '0;
    if (w_level_nxt != '0) begin
      if (w_write && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_nxt = push_data;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  // Storage array write port (no reset needed, contents qualified by level)
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers, level and registered head outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_level      <= '0;
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
    end else begin
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_level      <= w_level_nxt;
      r_head_valid <= (w_level_nxt != '0);
      r_head_data  <= w_head_nxt;
    end
  end

  assign head_valid = r_head_valid;
  assign head_data  = r_head_data;
  assign level      = r_level;

endmodule

// File: rtl/nonce_collector.sv
// rtl/nonce_collector.sv - tags miner hits with the work id and queues them for the host
// Optional duplicate-hit suppression: define NONCE_COLLECTOR_DEDUP_EN.
module nonce_collector
  import miner_pkg::*;
#(
  parameter int DEPTH     = COLLECTOR_DEPTH,
  parameter int WORK_ID_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WORK_ID_W-1:0]       work_id,
  input  logic                       new_work,
  input  logic                       nonce_found,
  input  logic [31:0]                nonce_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_nonce,
  output logic [WORK_ID_W-1:0]       out_work_id,
  output logic                       overflow,
  output logic [15:0]                found_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = WORK_ID_W + 32;

  logic [WORK_ID_W-1:0]   r_cur_id;
  logic                   r_overflow;
  logic [FOUND_CNT_W-1:0] r_found_count;

  logic                   w_head_valid;
  logic [ENT_W-1:0]       w_head_data;
  logic [LVL_W-1:0]       w_level;
  logic                   w_pop;
  logic                   w_room;
  logic                   w_dup;
  logic                   w_hit;
  logic                   w_push;
  logic                   w_drop;

`ifdef NONCE_COLLECTOR_DEDUP_EN
  nonce_t r_last_nonce;
  logic   r_last_vld;

  // Remember the last accepted nonce for the current work
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_nonce <= '0;
      r_last_vld   <= 1'b0;
    end else if (new_work) begin
      r_last_vld   <= 1'b0;
    end else if (w_push) begin
      r_last_nonce <= nonce_in;
      r_last_vld   <= 1'b1;
    end
  end

  assign w_dup = r_last_vld && (nonce_in == r_last_nonce);
`else
  assign w_dup = 1'b0;
`endif

  // A flush discards any same-cycle hit and pop; room includes a same-cycle pop
  assign w_pop  = w_head_valid && out_ready && !new_work;
  assign w_room = (w_level < LVL_W'(DEPTH)) || (w_head_valid && out_ready);
  assign w_hit  = nonce_found && !new_work && !w_dup;
  assign w_push = w_hit && w_room;
  assign w_drop = w_hit && !w_room;

  // Work tag latch, sticky overflow and saturating hit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_id      <= '0;
      r_overflow    <= 1'b0;
      r_found_count <= '0;
    end else if (new_work) begin
      r_cur_id      <= work_id;
      r_overflow    <= 1'b0;
      r_found_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_push && (r_found_count != '1)) begin
        r_found_count <= r_found_count + FOUND_CNT_W'(1);
      end
    end
  end

  nonce_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (new_work),
    .push       (w_push),
    .push_data  ({r_cur_id, nonce_in}),
    .pop        (w_pop),
    .head_valid (w_head_valid),
    .head_data  (w_head_data),
    .level      (w_level)
  );

  assign out_valid   = w_head_valid;
  assign out_work_id = w_head_data[ENT_W-1:32];
  assign out_nonce   = w_head_data[31:0];
  assign overflow    = r_overflow;
  assign found_count = r_found_count;
  assign level       = w_level;

endmodule
